// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
//   Shared types and constants for the logic-BIST pattern controller.
//
//   Contents:
//     bist_state_t       controller state encoding
//     BIST_TAPS          feedback tap mask (bits 15, 13, 12, 10), shared by the
//                        pattern LFSR and the response MISR
//     BIST_DEFAULT_SEED  power-on seed for the pattern LFSR
//     bist_step()        one shift of a tapped register with parallel XOR-in
// ---------------------------------------------------------------------------
package bist_pkg;

  // Controller states. Encodings are fixed so that the register value seen
  // in a waveform viewer maps directly onto a state name.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_RUN_A   = 3'd2,
    ST_RUN_B   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } bist_state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, expressed as the register bits that feed
  // the XOR into bit 0 of a left-shifting Fibonacci register.
  localparam logic [15:0] BIST_TAPS = 16'hB400;

  localparam logic [15:0] BIST_DEFAULT_SEED = 16'hACE1;

  // Shift left by one, insert the parity of the tapped bits at bit 0, then
  // fold in the parallel input. With par = 0 this is a plain LFSR step; with
  // a response word it is a MISR step.
  function automatic logic [15:0] bist_step(input logic [15:0] cur,
                                            input logic [15:0] par);
    return {cur[14:0], ^(cur & BIST_TAPS)} ^ par;
  endfunction

endpackage

// File: rtl/lfsr_misr16.sv
// ---------------------------------------------------------------------------
// lfsr_misr16
//   16-bit Fibonacci shift register usable either as a pattern LFSR
//   (par_in tied to zero) or as a multiple-input signature register
//   (par_in carries the response bits to compact).
//
//   Ports:
//     clk       in   1   clock
//     rst_n     in   1   asynchronous active-low reset, clears the register
//     load      in   1   synchronous load of load_val, wins over shift
//     load_val  in  16   value to load
//     shift     in   1   advance one step, XOR-ing in par_in
//     par_in    in  16   parallel input folded in on every shift
//     q         out 16   current register contents
// ---------------------------------------------------------------------------
module lfsr_misr16
  import bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        shift,
  input  logic [15:0] par_in,
  output logic [15:0] q
);

  // Load has priority so a session seed can never be disturbed by a shift
  // request arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 16'h0000;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= bist_step(q, par_in);
    end
  end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// bist_pattern_ctrl
//   Logic-BIST controller for the 16-input AND-tree test block. A pattern
//   LFSR drives the tree inputs, a MISR compacts the tree's out and
//   obs_point responses. Each session runs NUM_PATTERNS patterns with the
//   control point released (RUN_A), then NUM_PATTERNS more with it forced
//   (RUN_B), and finally compares the signature against golden_sig.
//
//   Parameters:
//     NUM_PATTERNS  patterns per phase, 1..65535
//     LFSR_SEED     nonzero pattern seed
//
//   Ports:
//     clk           in   1   sole clock
//     rst_n         in   1   asynchronous active-low reset
//     start         in   1   session request, honoured only in IDLE or DONE
//     golden_sig    in  16   expected signature, used in COMPARE
//     dut_out_i     in   1   tree out response
//     dut_obs_i     in   1   tree obs_point response
//     pat_out       out 16   pattern applied to the tree inputs
//     test_mode_o   out  1   tree test_mode
//     cp_force_1_o  out  1   tree cp_force_1 (forced phase only)
//     busy          out  1   session in progress
//     done          out  1   session complete, held until next start
//     pass          out  1   signature matched golden_sig, valid with done
//     signature     out 16   MISR contents, frozen in DONE
//
//   All outputs are decoded from registers; no input reaches an output
//   combinationally.
// ---------------------------------------------------------------------------
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter logic [15:0] LFSR_SEED    = BIST_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] golden_sig,
  input  logic        dut_out_i,
  input  logic        dut_obs_i,
  output logic [15:0] pat_out,
  output logic        test_mode_o,
  output logic        cp_force_1_o,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [15:0] LAST_CNT = 16'(NUM_PATTERNS - 1);

  bist_state_t state;
  bist_state_t state_nxt;
  logic [15:0] cnt;
  logic        pass_q;
  logic [15:0] lfsr_q;
  logic [15:0] misr_q;
  logic        running;
  logic        phase_end;
  logic        accept_start;
  logic        seeding;

  assign running      = (state == ST_RUN_A) || (state == ST_RUN_B);
  assign phase_end    = running && (cnt == LAST_CNT);
  assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign seeding      = (state == ST_SEED);

  // Session sequencing. start is only looked at from the two resting states,
  // so a stray request during a run cannot shorten or restart it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_SEED;
      ST_SEED:    state_nxt = ST_RUN_A;
      ST_RUN_A:   if (phase_end) state_nxt = ST_RUN_B;
      ST_RUN_B:   if (phase_end) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = ST_DONE;
      ST_DONE:    if (start) state_nxt = ST_SEED;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pattern counter within a phase. It returns to zero at the phase boundary
  // so RUN_B counts from scratch while the LFSR simply keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'h0000;
    end else if (seeding) begin
      cnt <= 16'h0000;
    end else if (running) begin
      if (phase_end) begin
        cnt <= 16'h0000;
      end else begin
        cnt <= cnt + 16'h0001;
      end
    end
  end

  // The verdict is cleared on the accepting edge so a stale pass can never
  // be seen alongside a new session, and is captured once in COMPARE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else if (accept_start) begin
      pass_q <= 1'b0;
    end else if (state == ST_COMPARE) begin
      pass_q <= (misr_q == golden_sig);
    end
  end

  // Pattern generator: reseeded once per session, free-running across both
  // phases.
  lfsr_misr16 u_pattern_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seeding),
    .load_val (LFSR_SEED),
    .shift    (running),
    .par_in   (16'h0000),
    .q        (lfsr_q)
  );

  // Response compactor: cleared in SEED, absorbs one response pair per
  // applied pattern and holds its value outside the run phases.
  lfsr_misr16 u_response_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seeding),
    .load_val (16'h0000),
    .shift    (running),
    .par_in   ({14'b0, dut_obs_i, dut_out_i}),
    .q        (misr_q)
  );

  // Output decode. The tree only sees a pattern while it is being measured,
  // keeping it quiescent (all zeros) the rest of the time.
  always_comb begin
    pat_out      = running ? lfsr_q : 16'h0000;
    busy         = seeding || running || (state == ST_COMPARE);
    test_mode_o  = seeding || running || (state == ST_COMPARE);
    cp_force_1_o = (state == ST_RUN_B);
    done         = (state == ST_DONE);
    pass         = pass_q;
    signature    = misr_q;
  end

endmodule
